// File: rtl/br_credit_sender_rv.sv
// Credit sender: turns a ready/valid producer into a credit/valid stream and owns the credit counter.
// Define BR_CREDIT_SENDER_REG_OUT_EN to drive pop_valid/pop_data from flops (one extra cycle of latency).
module br_credit_sender_rv #(
  parameter int BitWidth = 1,
  parameter int MaxCredit = 2,
  localparam int CreditWidth = $clog2(MaxCredit + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   push_ready,
  input  logic                   push_valid,
  input  logic [BitWidth-1:0]    push_data,
  output logic                   pop_valid,
  output logic [BitWidth-1:0]    pop_data,
  input  logic                   pop_credit,
  input  logic [CreditWidth-1:0] credit_initial,
  input  logic [CreditWidth-1:0] credit_withhold,
  output logic [CreditWidth-1:0] credit_count,
  output logic                   credit_available
);

  localparam logic [CreditWidth-1:0] MaxCount = CreditWidth'(MaxCredit);

  typedef enum logic {
    INIT,
    ACTIVE
  } state_e;

  state_e                 state_q, state_d;
  logic [CreditWidth-1:0] credit_count_q, credit_count_d;
  logic                   accept;

`ifdef BR_CREDIT_SENDER_REG_OUT_EN
  logic                   pop_valid_q, pop_valid_d;
  logic [BitWidth-1:0]    pop_data_q, pop_data_d;
`endif

  always_comb begin
    state_d          = state_q;
    credit_count_d   = credit_count_q;
    credit_available = (state_q == ACTIVE) && (credit_count_q > credit_withhold);
    push_ready       = credit_available;
    accept           = push_valid & push_ready;

    // Credits returned during INIT are dropped; the load value wins.
    case (state_q)
      INIT: begin
        credit_count_d = credit_initial;
        state_d        = ACTIVE;
      end
      ACTIVE: begin
        if (pop_credit && !accept) begin
          if (credit_count_q != MaxCount) begin
            credit_count_d = credit_count_q + 1'b1;
          end
        end else if (accept && !pop_credit) begin
          credit_count_d = credit_count_q - 1'b1;
        end
      end
      default: state_d = INIT;
    endcase

`ifdef BR_CREDIT_SENDER_REG_OUT_EN
    pop_valid_d = accept;
    pop_data_d  = accept ? push_data : '0;
    pop_valid   = pop_valid_q;
    pop_data    = pop_data_q;
`else
    // Gating data with accept keeps pop_data at zero while in reset.
    pop_valid   = accept;
    pop_data    = accept ? push_data : '0;
`endif
  end

  assign credit_count = credit_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= INIT;
      credit_count_q <= '0;
    end else begin
      state_q        <= state_d;
      credit_count_q <= credit_count_d;
    end
  end

`ifdef BR_CREDIT_SENDER_REG_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == ACTIVE) && (credit_count_q == MaxCount) && pop_credit && !accept));

  a_initial_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == INIT) |-> (credit_initial <= MaxCount));

  a_upstream_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (push_valid && !push_ready) |=> (push_valid && $stable(push_data)));

endmodule

// File: tb/tb_br_credit_sender_rv.sv
// Self-checking bench for br_credit_sender_rv: directed scenarios followed by random traffic,
// all compared against a counter-level model of the credit rules.
module tb_br_credit_sender_rv;

   localparam int BitWidth    = 4;
   localparam int MaxCredit   = 2;
   localparam int CreditWidth = $clog2(MaxCredit + 1);

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   push_ready;
   logic                   push_valid;
   logic [BitWidth-1:0]    push_data;
   logic                   pop_valid;
   logic [BitWidth-1:0]    pop_data;
   logic                   pop_credit;
   logic [CreditWidth-1:0] credit_initial;
   logic [CreditWidth-1:0] credit_withhold;
   logic [CreditWidth-1:0] credit_count;
   logic                   credit_available;

   // Reference model: a plain credit count plus the last beat, tracked per cycle
   int                     mCnt;
   bit                     mActive;
   bit                     mPrevAcc;
   logic [BitWidth-1:0]    mPrevData;
   bit                     lastStall;
   logic [BitWidth-1:0]    lastData;
   int                     testCount;
   int                     failCount;

   br_credit_sender_rv #(
      .BitWidth (BitWidth),
      .MaxCredit(MaxCredit)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .push_ready      (push_ready),
      .push_valid      (push_valid),
      .push_data       (push_data),
      .pop_valid       (pop_valid),
      .pop_data        (pop_data),
      .pop_credit      (pop_credit),
      .credit_initial  (credit_initial),
      .credit_withhold (credit_withhold),
      .credit_count    (credit_count),
      .credit_available(credit_available)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // One comparison: counts it, and on a miss counts the failure and reports it
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs (entered just after a rising edge), check the outputs at the
   // falling edge against the model, then advance the model across the next rising edge
   task automatic applyStimulus(input bit pv, input logic [BitWidth-1:0] pd, input bit pc,
                                input logic [CreditWidth-1:0] wh);
      bit expReady;
      bit acc;
      push_valid      = pv;
      push_data       = pd;
      pop_credit      = pc;
      credit_withhold = wh;
      @(negedge clk);
      expReady = mActive && (mCnt > int'(wh));
      acc      = pv && expReady;
      checkOutput("credit_count", 32'(credit_count), 32'(mCnt));
      checkOutput("push_ready", 32'(push_ready), 32'(expReady));
      checkOutput("credit_available", 32'(credit_available), 32'(expReady));
`ifdef BR_CREDIT_SENDER_REG_OUT_EN
      checkOutput("pop_valid", 32'(pop_valid), 32'(mPrevAcc));
      if (mPrevAcc) checkOutput("pop_data", 32'(pop_data), 32'(mPrevData));
`else
      checkOutput("pop_valid", 32'(pop_valid), 32'(acc));
      if (acc) checkOutput("pop_data", 32'(pop_data), 32'(pd));
`endif
      @(posedge clk);
      if (!mActive) begin
         mCnt    = int'(credit_initial);
         mActive = 1'b1;
      end else begin
         mCnt = mCnt + int'(pc) - int'(acc);
      end
      mPrevAcc  = acc;
      mPrevData = pd;
      lastStall = pv && !expReady;
      lastData  = pd;
      #1;
   endtask

   // Directed scenarios first, then random traffic, then an asynchronous reset mid-stream
   initial begin
      testCount       = 0;
      failCount       = 0;
      mCnt            = 0;
      mActive         = 1'b0;
      mPrevAcc        = 1'b0;
      mPrevData       = '0;
      lastStall       = 1'b0;
      lastData        = '0;
      rst_n           = 1'b0;
      push_valid      = 1'b0;
      push_data       = '0;
      pop_credit      = 1'b0;
      credit_initial  = 2'd2;
      credit_withhold = '0;

      // Everything idles at zero while reset is held
      #2;
      checkOutput("rst_credit_count", 32'(credit_count), 32'd0);
      checkOutput("rst_push_ready", 32'(push_ready), 32'd0);
      checkOutput("rst_pop_valid", 32'(pop_valid), 32'd0);
      checkOutput("rst_pop_data", 32'(pop_data), 32'd0);
      checkOutput("rst_credit_available", 32'(credit_available), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Init: zero in INIT, then credit_initial loaded and ready rises
      applyStimulus(1'b0, 4'h0, 1'b0, 2'd0);
      applyStimulus(1'b0, 4'h0, 1'b0, 2'd0);

      // Exhaust: A and B pass, C stalls until a credit comes back
      applyStimulus(1'b1, 4'hA, 1'b0, 2'd0);
      applyStimulus(1'b1, 4'hB, 1'b0, 2'd0);
      applyStimulus(1'b1, 4'hC, 1'b0, 2'd0);
      applyStimulus(1'b1, 4'hC, 1'b1, 2'd0);
      applyStimulus(1'b1, 4'hC, 1'b0, 2'd0);

      // Simultaneous return and accept holds the count at one, one beat per cycle
      applyStimulus(1'b0, 4'h0, 1'b1, 2'd0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 4'(i + 1), 1'b1, 2'd0);
      end

      // Withhold: two credits all held back, then release exactly one
      applyStimulus(1'b0, 4'h0, 1'b1, 2'd0);
      applyStimulus(1'b1, 4'h7, 1'b0, 2'd2);
      applyStimulus(1'b1, 4'h7, 1'b0, 2'd1);
      applyStimulus(1'b1, 4'h8, 1'b0, 2'd1);
      applyStimulus(1'b1, 4'h8, 1'b1, 2'd1);
      applyStimulus(1'b1, 4'h8, 1'b0, 2'd1);

      // Single beat 0x5 followed by idle, so its presentation and credit drop are isolated
      applyStimulus(1'b1, 4'h5, 1'b0, 2'd0);
      applyStimulus(1'b0, 4'h0, 1'b0, 2'd0);
      applyStimulus(1'b0, 4'h0, 1'b0, 2'd0);

      // Random traffic that respects the upstream hold rule and never overflows the counter
      for (int i = 0; i < 300; i++) begin
         bit                   pv;
         bit                   pc;
         logic [BitWidth-1:0]  pd;
         logic [CreditWidth-1:0] wh;
         if (lastStall) begin
            pv = 1'b1;
            pd = lastData;
         end else begin
            pv = 1'($urandom_range(0, 1));
            pd = 4'($urandom_range(0, 15));
         end
         pc = (mCnt < MaxCredit) && ($urandom_range(0, 1) == 1);
         wh = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         applyStimulus(pv, pd, pc, wh);
      end
      while (lastStall) begin
         applyStimulus(1'b1, lastData, mCnt < MaxCredit, 2'd0);
      end

      // Bring the count to one, then accept a beat and pull reset between edges
      while (mCnt != 1) begin
         if (mCnt > 1) applyStimulus(1'b1, 4'h1, 1'b0, 2'd0);
         else          applyStimulus(1'b0, 4'h0, 1'b1, 2'd0);
      end
      push_valid      = 1'b1;
      push_data       = 4'h9;
      pop_credit      = 1'b0;
      credit_withhold = 2'd0;
      #3;
      checkOutput("midop_credit_count", 32'(credit_count), 32'd1);
`ifdef BR_CREDIT_SENDER_REG_OUT_EN
      checkOutput("midop_pop_valid", 32'(pop_valid), 32'(mPrevAcc));
`else
      checkOutput("midop_pop_valid", 32'(pop_valid), 32'd1);
`endif
      rst_n = 1'b0;
      #1;
      checkOutput("async_credit_count", 32'(credit_count), 32'd0);
      checkOutput("async_push_ready", 32'(push_ready), 32'd0);
      checkOutput("async_pop_valid", 32'(pop_valid), 32'd0);
      checkOutput("async_pop_data", 32'(pop_data), 32'd0);
      checkOutput("async_credit_available", 32'(credit_available), 32'd0);
      push_valid     = 1'b0;
      credit_initial = 2'd1;
      @(posedge clk);
      #2;
      mCnt      = 0;
      mActive   = 1'b0;
      mPrevAcc  = 1'b0;
      lastStall = 1'b0;
      rst_n     = 1'b1;

      // Re-init reloads the new initial value; a credit pulse during INIT is dropped
      applyStimulus(1'b0, 4'h0, 1'b1, 2'd0);
      applyStimulus(1'b0, 4'h0, 1'b0, 2'd0);
      applyStimulus(1'b1, 4'h6, 1'b0, 2'd0);
      applyStimulus(1'b0, 4'h0, 1'b0, 2'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
